// File: rtl/bcd_pkg.sv
// Shared BCD codec definitions: sign nibble codes and converter state encoding.
package bcd_pkg;

  localparam logic [3:0] SGN_MINUS = 4'hA;
  localparam logic [3:0] SGN_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
interface bcd2bin_seq_if #(
  parameter int width  = 6,
  parameter int digits = 2
);
  logic                  start;
  logic [4*digits-1:0]   bcd;
  logic [3:0]            bcd_sgn;
  logic                  busy;
  logic                  done;
  logic [width-1:0]      bin;
  logic                  ovf;
  logic                  bad_digit;

  modport master (output start, bcd, bcd_sgn,
                  input  busy, done, bin, ovf, bad_digit);
  modport slave  (input  start, bcd, bcd_sgn,
                  output busy, done, bin, ovf, bad_digit);
endinterface

// File: rtl/bcd2bin_seq_mac10.sv
// One decimal step: acc*10 + digit built from shifts, plus a non-decimal digit flag.
module bcd_mac10 #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] acc_i,
  input  logic [3:0]    digit_i,
  output logic [AW-1:0] sum_o,
  output logic          bad_o
);

  assign sum_o = (acc_i << 3) + (acc_i << 1) + AW'(digit_i);
  assign bad_o = (digit_i > 4'd9);

endmodule

// File: rtl/bcd2bin_seq.sv
// Sign-magnitude BCD to two's-complement converter, one digit per clock, MSD first.
//   state | meaning
//   IDLE  | waiting for start; last result held
//   CONV  | accumulating one digit per edge
//   FIN   | range check, register result, pulse done
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int width  = 6,
  parameter int digits = 2
) (
  input logic          clk,
  input logic          rst,
  bcd2bin_seq_if.slave bus
);

  localparam int AW   = 4 * digits;
  localparam int IDXW = (digits > 1) ? $clog2(digits) : 1;
  localparam int CW   = ((AW > width) ? AW : width) + 1;
  localparam logic [CW-1:0]    LIM     = CW'(1) << (width - 1);
  localparam logic [width-1:0] BIN_MIN = {1'b1, {(width-1){1'b0}}};
  localparam logic [width-1:0] BIN_MAX = ~BIN_MIN;

  bcd_state_e       state_q;
  logic [AW-1:0]    acc_q;
  logic [IDXW-1:0]  idx_q;
  logic [AW-1:0]    bcd_q;
  logic             minus_q;
  logic             bad_acc_q;
  logic             busy_q;
  logic             done_q;
  logic [width-1:0] bin_q;
  logic             ovf_q;
  logic             bad_q;

  logic [AW-1:0]    mac_sum;
  logic             mac_bad;
  logic [CW-1:0]    mag_ext;
  logic             over;
  logic [width-1:0] bin_d;
  logic             ovf_d;

  bcd_mac10 #(.AW(AW)) u_mac (
    .acc_i   (acc_q),
    .digit_i (bcd_q[{idx_q, 2'b00} +: 4]),
    .sum_o   (mac_sum),
    .bad_o   (mac_bad)
  );

  // Minus side reaches one further than plus: -2^(width-1) is representable.
  always_comb begin
    mag_ext = CW'(acc_q);
    over    = minus_q ? (mag_ext > LIM) : (mag_ext >= LIM);
    bin_d   = '0;
    ovf_d   = 1'b0;
    if (!bad_acc_q) begin
      ovf_d = over;
      if (over)         bin_d = minus_q ? BIN_MIN : BIN_MAX;
      else if (minus_q) bin_d = -mag_ext[width-1:0];
      else              bin_d = mag_ext[width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      bcd_q     <= '0;
      minus_q   <= 1'b0;
      bad_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_q     <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            bcd_q     <= bus.bcd;
            minus_q   <= (bus.bcd_sgn == SGN_MINUS);
            acc_q     <= '0;
            idx_q     <= IDXW'(digits - 1);
            bad_acc_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end
        end
        CONV: begin
          acc_q     <= mac_sum;
          bad_acc_q <= bad_acc_q | mac_bad;
          if (idx_q == '0) state_q <= FIN;
          else             idx_q   <= idx_q - 1'b1;
        end
        FIN: begin
          bin_q   <= bin_d;
          ovf_q   <= ovf_d;
          bad_q   <= bad_acc_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bin       = bin_q;
  assign bus.ovf       = ovf_q;
  assign bus.bad_digit = bad_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Vector table plus corner sequences for bcd2bin_seq (width=6, digits=2), scoreboarded on done.
module tb_bcd2bin_seq;

  typedef struct packed {
    logic [5:0] bin;
    logic       ovf;
    logic       bad;
  } exp_t;

  typedef struct {
    logic [7:0] bcd;
    logic [3:0] sgn;
    logic [5:0] bin;
    logic       ovf;
    logic       bad;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t held = '0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  bcd2bin_seq_if #(.width(6), .digits(2)) bus ();

  bcd2bin_seq #(.width(6), .digits(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] b, input logic [3:0] s);
    exp_t r;
    int   mag;
    r = '0;
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) begin
      r.bad = 1'b1;
      return r;
    end
    mag = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (s == 4'hA) begin
      if (mag > 32) begin r.ovf = 1'b1; r.bin = 6'b100000; end
      else r.bin = 6'(-mag);
    end else begin
      if (mag > 31) begin r.ovf = 1'b1; r.bin = 6'b011111; end
      else r.bin = 6'(mag);
    end
    return r;
  endfunction

  always @(posedge clk) rst_seen <= rst;

  // Scoreboard: results compared on done; outputs must otherwise hold their last value.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) held = '0;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bin", 32'(bus.bin), 32'(e.bin));
          chk("ovf", 32'(bus.ovf), 32'(e.ovf));
          chk("bad_digit", 32'(bus.bad_digit), 32'(e.bad));
          held = e;
        end
      end else begin
        chk("hold", 32'({bus.bin, bus.ovf, bus.bad_digit}), 32'(held));
      end
    end
  end

  task automatic wait_done(input string name, input int req_lat);
    int lat;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done) begin lat = c; break; end
      chk({name, "_busy"}, 32'(bus.busy), 32'(1));
    end
    chk({name, "_latency"}, 32'(lat), 32'(req_lat));
  endtask

  task automatic do_conv(input string name, input logic [7:0] b, input logic [3:0] s,
                         input exp_t e);
    @(negedge clk);
    bus.start = 1'b1; bus.bcd = b; bus.bcd_sgn = s;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, "_busy_after_start"}, 32'(bus.busy), 32'(1));
    wait_done(name, 3);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(bus.done), 32'(0));
    chk({name, "_busy_idle"}, 32'(bus.busy), 32'(0));
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{8'h25, 4'hF, 6'b011001, 1'b0, 1'b0};
    vecs[1]  = '{8'h32, 4'hA, 6'b100000, 1'b0, 1'b0};
    vecs[2]  = '{8'h32, 4'hF, 6'b011111, 1'b1, 1'b0};
    vecs[3]  = '{8'h99, 4'hA, 6'b100000, 1'b1, 1'b0};
    vecs[4]  = '{8'h00, 4'hA, 6'b000000, 1'b0, 1'b0};
    vecs[5]  = '{8'h3C, 4'hF, 6'b000000, 1'b0, 1'b1};
    vecs[6]  = '{8'h31, 4'hF, 6'b011111, 1'b0, 1'b0};
    vecs[7]  = '{8'h33, 4'hA, 6'b100000, 1'b1, 1'b0};
    vecs[8]  = '{8'h09, 4'hA, 6'b110111, 1'b0, 1'b0};
    vecs[9]  = '{8'hA0, 4'hA, 6'b000000, 1'b0, 1'b1};
    vecs[10] = '{8'h00, 4'hF, 6'b000000, 1'b0, 1'b0};
    vecs[11] = '{8'h15, 4'h5, 6'b001111, 1'b0, 1'b0};
    vecs[12] = '{8'h99, 4'hF, 6'b011111, 1'b1, 1'b0};

    bus.start = 1'b0; bus.bcd = '0; bus.bcd_sgn = 4'hF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_bin", 32'(bus.bin), 32'(0));
    chk("rst_ovf", 32'(bus.ovf), 32'(0));
    chk("rst_bad", 32'(bus.bad_digit), 32'(0));
    mon_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      e = '{bin: vecs[i].bin, ovf: vecs[i].ovf, bad: vecs[i].bad};
      do_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].sgn, e);
    end

    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      logic [3:0] s;
      b = 8'($urandom_range(0, 255));
      s = (i % 2 == 0) ? 4'hA : 4'hF;
      do_conv($sformatf("rnd%0d", i), b, s, model(b, s));
    end

    // Reset one edge into a conversion: aborted, nothing reported.
    @(negedge clk);
    bus.start = 1'b1; bus.bcd = 8'h25; bus.bcd_sgn = 4'hF;
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_bin", 32'(bus.bin), 32'(0));
    chk("abort_ovf", 32'(bus.ovf), 32'(0));
    repeat (5) @(negedge clk);
    chk("abort_no_result", 32'(sb.size()), 32'(0));
    do_conv("after_abort", 8'h07, 4'hF, '{bin: 6'b000111, ovf: 1'b0, bad: 1'b0});

    // Start re-pulsed while busy is ignored; start on the done cycle is accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.bcd = 8'h11; bus.bcd_sgn = 4'hF;
    sb.push_back('{bin: 6'b001011, ovf: 1'b0, bad: 1'b0});
    @(negedge clk);
    bus.bcd = 8'h22;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("repulse", 2);
    bus.start = 1'b1; bus.bcd = 8'h05; bus.bcd_sgn = 4'hF;
    sb.push_back('{bin: 6'b000101, ovf: 1'b0, bad: 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'(1));
    wait_done("b2b", 3);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
